// File: rtl/hmmm_pkg.sv
// Shared types and instruction-field helpers for the parametrised HMMM multicycle core.
// Field helpers work on a zero-extended 64-bit copy of the word, so callers can use any width.
package hmmm_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_HALT   = 4'h1,
        OP_SETN   = 4'h2,
        OP_ADD    = 4'h3,
        OP_SUB    = 4'h4,
        OP_LOADR  = 4'h5,
        OP_STORER = 4'h6,
        OP_JUMPN  = 4'h7,
        OP_JEQZN  = 4'h8,
        OP_JNEZN  = 4'h9,
        OP_JGTZN  = 4'hA,
        OP_JLTZN  = 4'hB,
        OP_ADDN   = 4'hC
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam int SLICE_W = 64;

    function automatic logic [3:0] instr_op(input logic [SLICE_W-1:0] instr, input int instr_w);
        return 4'(instr >> (instr_w - 4));
    endfunction

    // Register index idx (0 = rZ, 1 = rY) packed in the low bits of the field.
    function automatic logic [SLICE_W-1:0] reg_field(input logic [SLICE_W-1:0] field,
                                                     input int ra_w, input int idx);
        return (field >> (ra_w * idx)) & ((SLICE_W'(1) << ra_w) - SLICE_W'(1));
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > 4'hC;
    endfunction

    function automatic logic branch_taken(input logic [3:0] op, input logic zero, input logic neg);
        case (op)
            OP_JUMPN: return 1'b1;
            OP_JEQZN: return zero;
            OP_JNEZN: return !zero;
            OP_JGTZN: return !neg && !zero;
            OP_JLTZN: return neg;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// r0 is hardwired to zero; reads are combinational so a WB cycle still shows the old value.
module core_regfile
    import hmmm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   ra1,
    input  logic [RA_W-1:0]   ra2,
    input  logic [RA_W-1:0]   dbg_ra,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] dbg_rd,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1    = (ra1 == '0)    ? '0 : regs[ra1];
    assign rd2    = (ra2 == '0)    ? '0 : regs[ra2];
    assign dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule

// File: rtl/hmmm_multicycle_core.sv
// Multicycle HMMM-style core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// handshaked instruction and data memory ports living outside the core.
module hmmm_multicycle_core
    import hmmm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREG     = 4,
    parameter int PC_W     = 8,
    parameter int IMM_W    = 8,
    localparam int RA_W    = $clog2(NREG),
    localparam int INSTR_W = 4 + RA_W + IMM_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [PC_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic [RA_W-1:0]    dbg_ra,
    output logic [DATA_W-1:0]  dbg_rd,
    output logic [PC_W-1:0]    pc_o,
    output logic               halted,
    output logic               illegal
);

    state_e                    state, state_n;
    logic [PC_W-1:0]           pc;
    logic [INSTR_W-1:0]        ir;
    logic                      illegal_q;
    logic [DATA_W-1:0]         a_q, b_q, res_q;

    logic [3:0]                op;
    logic [RA_W-1:0]           rx, ry, rz, rd1_addr, rd2_addr;
    logic [IMM_W-1:0]          field;
    logic signed [IMM_W-1:0]   imm_s;
    logic signed [DATA_W-1:0]  imm_ext, a_s;
    logic [DATA_W-1:0]         rd1, rd2, alu_res;
    logic                      taken, is_rr;

    assign op    = instr_op(SLICE_W'(ir), INSTR_W);
    assign rx    = ir[IMM_W +: RA_W];
    assign field = ir[IMM_W-1:0];
    assign ry    = RA_W'(reg_field(SLICE_W'(field), RA_W, 1));
    assign rz    = RA_W'(reg_field(SLICE_W'(field), RA_W, 0));
    assign imm_s   = $signed(field);
    assign imm_ext = DATA_W'(imm_s);
    assign a_s     = $signed(a_q);

    // add/sub read rY,rZ; everything else reads rX on port 1 and rY on port 2.
    assign is_rr    = (op == OP_ADD) || (op == OP_SUB);
    assign rd1_addr = is_rr ? ry : rx;
    assign rd2_addr = is_rr ? rz : ry;

    core_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .ra1    (rd1_addr),
        .ra2    (rd2_addr),
        .dbg_ra (dbg_ra),
        .rd1    (rd1),
        .rd2    (rd2),
        .dbg_rd (dbg_rd),
        .we     (state == S_WB),
        .wa     (rx),
        .wd     (res_q)
    );

    assign taken = branch_taken(op, a_q == '0, a_s < 0);

    always_comb begin
        alu_res = a_q;
        case (op)
            OP_SETN: alu_res = imm_ext;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_ADDN: alu_res = a_q + imm_ext;
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  if (imem_ack) state_n = S_DECODE;
            S_DECODE: state_n = is_illegal(op) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_HALT:              state_n = S_HALT;
                    OP_LOADR, OP_STORER:  state_n = S_MEM;
                    OP_SETN, OP_ADD, OP_SUB, OP_ADDN: state_n = S_WB;
                    default:              state_n = S_FETCH;
                endcase
            end
            S_MEM:    if (dmem_ack) state_n = (op == OP_LOADR) ? S_WB : S_FETCH;
            S_WB:     state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && imem_ack) begin
                ir <= imem_rdata;
                pc <= pc + PC_W'(1);
            end
            if (state == S_DECODE && is_illegal(op)) illegal_q <= 1'b1;
            if (state == S_EXEC && taken) pc <= field[PC_W-1:0];
        end
    end

    // Operand and result latches carry data only; their contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == S_DECODE) begin
            a_q <= rd1;
            b_q <= rd2;
        end
        if (state == S_EXEC) res_q <= alu_res;
        if (state == S_MEM && dmem_ack && op == OP_LOADR) res_q <= dmem_rdata;
    end

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = (state == S_MEM) && (op == OP_STORER);
    assign dmem_addr  = PC_W'(b_q);
    assign dmem_wdata = a_q;
    assign pc_o       = pc;
    assign halted     = (state == S_HALT);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_hmmm_multicycle_core.sv
// Table-driven bench for hmmm_multicycle_core with behavioural instruction/data memories,
// plus hand-written sequences for wait states, pc wrap, illegal opcodes and reset mid-access.
module tb_hmmm_multicycle_core;

    localparam logic [3:0] HLT = 4'h1, SETN = 4'h2, ADD = 4'h3, SUB = 4'h4, LDR = 4'h5,
                           STR = 4'h6, JMP = 4'h7, JEQZ = 4'h8, JNEZ = 4'h9, JGTZ = 4'hA,
                           JLTZ = 4'hB, ADDN = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [13:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dbg_ra;
    logic [7:0]  dbg_rd, pc_o;
    logic        halted, illegal;

    hmmm_multicycle_core #(.DATA_W(8), .NREG(4), .PC_W(8), .IMM_W(8)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .pc_o(pc_o), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [13:0] imem [256];
    logic [7:0]  dmem [256];
    int          imem_delay = 0;
    int          imem_cnt = 0;
    logic        dmem_ack_en;
    logic [7:0]  fetch_log [$];

    assign imem_ack   = imem_req && (imem_cnt == imem_delay);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && dmem_ack_en;
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) imem_cnt <= 0;
        else imem_cnt <= imem_cnt + 1;
        if (reset) fetch_log.delete();
        else if (imem_req && imem_ack) fetch_log.push_back(imem_addr);
        if (!reset && dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    typedef struct {
        logic [11:0][13:0] prog;
        logic [3:0][7:0]   exp_reg;
        logic [7:0]        exp_pc;
        int                exp_cycles;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [13:0] ins(input logic [3:0] op, input logic [1:0] rx, input logic [7:0] f);
        return {op, rx, f};
    endfunction

    function automatic logic [13:0] rr(input logic [3:0] op, input logic [1:0] rx,
                                       input logic [1:0] ry, input logic [1:0] rz);
        return {op, rx, 4'b0000, ry, rz};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int v, input int a, input logic [13:0] w);
        vecs[v].prog[a] = w;
    endtask

    task automatic set_exp(input int v, input logic [7:0] r1, input logic [7:0] r2,
                           input logic [7:0] r3, input logic [7:0] pc, input int cyc);
        vecs[v].exp_reg    = {r3, r2, r1, 8'h00};
        vecs[v].exp_pc     = pc;
        vecs[v].exp_cycles = cyc;
    endtask

    task automatic clear_imem();
        for (int a = 0; a < 256; a++) imem[a] = ins(HLT, 2'd0, 8'h00);
    endtask

    task automatic load_vec(input int v);
        clear_imem();
        for (int a = 0; a < 12; a++) imem[a] = vecs[v].prog[a];
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_reg(input logic [1:0] ra, output logic [7:0] v);
        dbg_ra = ra;
        #1;
        v = dbg_rd;
    endtask

    initial begin
        int          n, cnt;
        logic [7:0]  v8;
        logic [7:0]  exp_f [5];

        reset = 1'b1;
        dbg_ra = 2'd0;
        dmem_ack_en = 1'b1;

        for (int v = 0; v < 6; v++)
            for (int a = 0; a < 12; a++) vecs[v].prog[a] = ins(HLT, 2'd0, 8'h00);

        put(0, 0, ins(SETN, 2'd1, 8'h05)); put(0, 1, ins(SETN, 2'd2, 8'h03));
        put(0, 2, rr(SUB, 2'd3, 2'd1, 2'd2));
        set_exp(0, 8'h05, 8'h03, 8'h02, 8'h04, 15);

        put(1, 0, ins(SETN, 2'd1, 8'h7F)); put(1, 1, ins(ADDN, 2'd1, 8'h01));
        put(1, 2, rr(ADD, 2'd2, 2'd1, 2'd1)); put(1, 3, ins(SETN, 2'd3, 8'hFF));
        set_exp(1, 8'h80, 8'h00, 8'hFF, 8'h05, 19);

        put(2, 0, ins(SETN, 2'd0, 8'h07)); put(2, 1, rr(ADD, 2'd1, 2'd0, 2'd0));
        put(2, 2, ins(SETN, 2'd2, 8'h09)); put(2, 3, rr(SUB, 2'd3, 2'd0, 2'd2));
        set_exp(2, 8'h00, 8'h09, 8'hF7, 8'h05, 19);

        put(3, 0, ins(SETN, 2'd3, 8'hFF)); put(3, 1, ins(JLTZ, 2'd3, 8'h04));
        put(3, 2, ins(SETN, 2'd1, 8'h01)); put(3, 4, ins(SETN, 2'd2, 8'h02));
        put(3, 5, ins(JGTZ, 2'd0, 8'h08)); put(3, 6, ins(SETN, 2'd1, 8'h07));
        set_exp(3, 8'h07, 8'h02, 8'hFF, 8'h08, 21);

        put(4, 0, ins(SETN, 2'd1, 8'h00)); put(4, 1, ins(JEQZ, 2'd1, 8'h03));
        put(4, 3, ins(SETN, 2'd2, 8'h01)); put(4, 4, ins(JNEZ, 2'd2, 8'h06));
        put(4, 6, ins(JNEZ, 2'd1, 8'h08)); put(4, 7, ins(SETN, 2'd3, 8'h33));
        put(4, 8, ins(JMP, 2'd0, 8'h0A));  put(4, 9, ins(SETN, 2'd1, 8'h55));
        set_exp(4, 8'h00, 8'h01, 8'h33, 8'h0B, 27);

        put(5, 0, ins(SETN, 2'd1, 8'hA5)); put(5, 1, ins(SETN, 2'd2, 8'h20));
        put(5, 2, rr(STR, 2'd1, 2'd2, 2'd0)); put(5, 3, rr(LDR, 2'd3, 2'd2, 2'd0));
        set_exp(5, 8'hA5, 8'h20, 8'hA5, 8'h05, 20);

        for (int v = 0; v < 6; v++) begin
            load_vec(v);
            reset_dut();
            run_to_halt(300, n);
            check($sformatf("v%0d_halted", v), 32'(halted), 32'd1);
            check($sformatf("v%0d_cycles", v), 32'(n), 32'(vecs[v].exp_cycles));
            check($sformatf("v%0d_pc", v), 32'(pc_o), 32'(vecs[v].exp_pc));
            for (int r = 0; r < 4; r++) begin
                read_reg(2'(r), v8);
                check($sformatf("v%0d_r%0d", v, r), 32'(v8), 32'(vecs[v].exp_reg[r]));
            end
        end
        check("store_mem_20", 32'(dmem[8'h20]), 32'hA5);

        // Illegal opcode: halts, sets the sticky flag and issues no further requests.
        clear_imem();
        imem[0] = ins(SETN, 2'd1, 8'h01);
        imem[1] = 14'h3C00;
        imem[2] = ins(SETN, 2'd2, 8'h02);
        reset_dut();
        run_to_halt(100, n);
        check("ill_illegal", 32'(illegal), 32'd1);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_cycles", 32'(n), 32'd6);
        check("ill_pc", 32'(pc_o), 32'h02);
        cnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (imem_req || dmem_req) cnt++;
        end
        check("ill_no_req", 32'(cnt), 32'd0);
        read_reg(2'd2, v8);
        check("ill_r2", 32'(v8), 32'h00);

        reset_dut();
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        check("rst_imem_addr", 32'(imem_addr), 32'h00);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_pc", 32'(pc_o), 32'h00);
        read_reg(2'd1, v8);
        check("rst_r1", 32'(v8), 32'h00);

        // Delayed fetch ack: request and address hold until the ack cycle.
        load_vec(0);
        imem_delay = 3;
        reset_dut();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req && imem_addr == 8'h00 && pc_o == 8'h00) cnt++;
            @(posedge clk);
            #1;
        end
        check("dly_stable_cycles", 32'(cnt), 32'd4);
        check("dly_req_after_ack", 32'(imem_req), 32'd0);
        check("dly_pc_after_ack", 32'(pc_o), 32'h01);
        run_to_halt(300, n);
        read_reg(2'd3, v8);
        check("dly_r3", 32'(v8), 32'h02);
        imem_delay = 0;

        // pc wrap from 0xFF to 0x00 and branch targets, seen through the fetch trace.
        clear_imem();
        imem[8'h00] = ins(JNEZ, 2'd1, 8'h10);
        imem[8'h01] = ins(JMP, 2'd0, 8'hFF);
        imem[8'hFF] = ins(SETN, 2'd1, 8'h11);
        reset_dut();
        run_to_halt(200, n);
        exp_f = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h10};
        check("wrap_fetch_count", 32'(fetch_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < fetch_log.size(); i++)
            check($sformatf("wrap_fetch%0d", i), 32'(fetch_log[i]), 32'(exp_f[i]));
        check("wrap_pc", 32'(pc_o), 32'h11);
        read_reg(2'd1, v8);
        check("wrap_r1", 32'(v8), 32'h11);

        // Store held under wait states, then reset abandons the access.
        dmem_ack_en = 1'b0;
        load_vec(5);
        reset_dut();
        n = 0;
        while (!dmem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_addr", 32'(dmem_addr), 32'h20);
        check("st_wdata", 32'(dmem_wdata), 32'hA5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("st_hold_req", 32'(dmem_req), 32'd1);
        check("st_hold_bus", 32'({dmem_we, dmem_addr, dmem_wdata}), 32'({1'b1, 8'h20, 8'hA5}));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_dmem_req", 32'(dmem_req), 32'd0);
        check("mrst_pc", 32'(pc_o), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        dmem_ack_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
